// File: rtl/output_stream_tx.sv
// Output stream transmitter: buffers convolution results in a circular FIFO and
// presents them as an AXI-Stream master, tagging the last word of each frame.
module output_stream_tx #(
  parameter int unsigned OUTW  = 52,
  parameter int unsigned R     = 9,
  parameter int unsigned C     = 8,
  parameter int unsigned MAXK  = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [OUTW-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(MAXK+1)-1:0]    K,
  output logic [OUTW-1:0]              AXIS_TDATA,
  output logic                         AXIS_TVALID,
  input  logic                         AXIS_TREADY,
  output logic                         AXIS_TLAST,
  output logic                         frame_done
);

  localparam int unsigned KW  = $clog2(MAXK + 1);
  localparam int unsigned PCW = (R * C > 1) ? $clog2(R * C) : 1;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  logic [OUTW:0]    mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [PCW-1:0]   push_cnt;
  logic [KW-1:0]    k_lat;

  logic             push;
  logic             pop;
  logic [KW-1:0]    ke;
  int unsigned      n_words;
  logic             last_flag;
  logic [OUTW:0]    head;

  assign in_ready    = reset && (count < CW'(DEPTH));
  assign AXIS_TVALID = (count != '0);
  assign head        = mem[rd_ptr];
  assign AXIS_TDATA  = head[OUTW-1:0];
  assign AXIS_TLAST  = AXIS_TVALID && head[OUTW];

  assign push = in_valid && in_ready;
  assign pop  = AXIS_TVALID && AXIS_TREADY;

  // Kernel size is sampled on the first push of a frame and held until it ends.
  always_comb begin
    ke        = k_lat;
    n_words   = 32'd0;
    last_flag = 1'b0;
    if (push_cnt == '0) begin
      ke = K;
    end
    n_words   = (R - 32'(ke) + 32'd1) * (C - 32'(ke) + 32'd1);
    last_flag = (32'(push_cnt) == (n_words - 32'd1));
  end

  // Control state: pointers, occupancy, frame position, completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      push_cnt   <= '0;
      k_lat      <= '0;
      frame_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (push_cnt == '0) begin
          k_lat <= K;
        end
        push_cnt <= last_flag ? '0 : push_cnt + PCW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      frame_done <= pop && AXIS_TLAST;
    end
  end

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {last_flag, in_data};
    end
  end

endmodule

// File: tb/tb_output_stream_tx.sv
// Directed bench for output_stream_tx: frame tagging, backpressure, reset and
// throughput cases, with a queue-based reference checked on every transfer.
module tb_output_stream_tx;

  logic        clk;
  logic        reset;
  logic [51:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  K;
  logic [51:0] AXIS_TDATA;
  logic        AXIS_TVALID;
  logic        AXIS_TREADY;
  logic        AXIS_TLAST;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [52:0] exp_q[$];
  int          last_q[$];
  int          pop_idx  = 0;
  int          fd_count = 0;
  int          m_cnt    = 0;
  int          m_klat   = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [51:0] prev_data  = '0;
  logic        prev_last  = 1'b0;
  logic        prev_pl    = 1'b0;
  logic        rnd_mode   = 1'b0;

  output_stream_tx dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .K           (K),
    .AXIS_TDATA  (AXIS_TDATA),
    .AXIS_TVALID (AXIS_TVALID),
    .AXIS_TREADY (AXIS_TREADY),
    .AXIS_TLAST  (AXIS_TLAST),
    .frame_done  (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model and transfer monitor, sampled mid-cycle.
  always @(negedge clk) begin
    int          ke;
    int          n;
    logic        lst;
    logic [52:0] e;
    if (!reset) begin
      exp_q.delete();
      m_cnt      = 0;
      m_klat     = 0;
      prev_valid = 1'b0;
      prev_pl    = 1'b0;
    end else begin
      check("frame_done", 64'(frame_done), 64'(prev_pl));
      if (frame_done) fd_count++;
      if (prev_valid && !prev_ready) begin
        check("stall_tvalid", 64'(AXIS_TVALID), 64'(1));
        check("stall_tdata", 64'(AXIS_TDATA), 64'(prev_data));
        check("stall_tlast", 64'(AXIS_TLAST), 64'(prev_last));
      end
      if (AXIS_TVALID && AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          check("pop_underflow", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          check("tdata", 64'(AXIS_TDATA), 64'(e[51:0]));
          check("tlast", 64'(AXIS_TLAST), 64'(e[52]));
        end
        if (AXIS_TLAST) last_q.push_back(pop_idx);
        pop_idx++;
      end
      if (in_valid && in_ready) begin
        ke = (m_cnt == 0) ? int'(K) : m_klat;
        if (m_cnt == 0) m_klat = ke;
        n   = (9 - ke + 1) * (8 - ke + 1);
        lst = (m_cnt == n - 1);
        exp_q.push_back({lst, in_data});
        m_cnt = lst ? 0 : m_cnt + 1;
      end
      prev_valid = AXIS_TVALID;
      prev_ready = AXIS_TREADY;
      prev_data  = AXIS_TDATA;
      prev_last  = AXIS_TLAST;
      prev_pl    = AXIS_TVALID && AXIS_TREADY && AXIS_TLAST;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) AXIS_TREADY = 1'($urandom_range(0, 1));
  endtask

  task automatic push_word(input logic [51:0] d, input logic [2:0] k);
    int   guard;
    logic acc;
    guard    = 0;
    acc      = 1'b0;
    in_data  = d;
    K        = k;
    in_valid = 1'b1;
    while (!acc && guard < 300) begin
      acc = in_ready;
      tick();
      guard++;
    end
    if (!acc) check("push_timeout", 64'(acc), 64'(1));
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    in_valid = 1'b0;
    while ((AXIS_TVALID || exp_q.size() != 0) && g < budget) begin
      tick();
      g++;
    end
    tick();
    tick();
    check("drain_tvalid", 64'(AXIS_TVALID), 64'(0));
    check("drain_leftover", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst_tvalid_async", 64'(AXIS_TVALID), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_tlast", 64'(AXIS_TLAST), 64'(0));
    tick();
    tick();
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int lq0;
    int pb;
    int fd0;
    reset       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    K           = 3'd4;
    AXIS_TREADY = 1'b1;

    #2;
    check("reset_tvalid", 64'(AXIS_TVALID), 64'(0));
    check("reset_tlast", 64'(AXIS_TLAST), 64'(0));
    check("reset_frame_done", 64'(frame_done), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
    check("release_in_ready", 64'(in_ready), 64'(1));

    // K=4 frame of 30 words with a ready consumer.
    lq0 = last_q.size(); pb = pop_idx; fd0 = fd_count;
    push_word(52'd0, 3'd4);
    check("latency_tvalid", 64'(AXIS_TVALID), 64'(1));
    check("latency_tdata", 64'(AXIS_TDATA), 64'(0));
    for (int i = 1; i < 30; i++) push_word(52'(i), 3'd4);
    drain(100);
    check("f30_pops", 64'(pop_idx - pb), 64'(30));
    check("f30_last_cnt", 64'(last_q.size() - lq0), 64'(1));
    if (last_q.size() > lq0) check("f30_last_idx", 64'(last_q[lq0] - pb), 64'(29));
    check("f30_frame_done", 64'(fd_count - fd0), 64'(1));

    // Backpressure: fill to DEPTH, then release.
    pb = pop_idx;
    AXIS_TREADY = 1'b0;
    for (int i = 0; i < 8; i++) push_word(52'(100 + i), 3'd4);
    in_valid = 1'b0;
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_count", 64'(dut.count), 64'(8));
    in_data  = 52'd108;
    in_valid = 1'b1;
    tick(); tick(); tick();
    check("full_hold_count", 64'(dut.count), 64'(8));
    check("full_hold_ready", 64'(in_ready), 64'(0));
    AXIS_TREADY = 1'b1;
    push_word(52'd108, 3'd4);
    push_word(52'd109, 3'd4);
    drain(100);
    check("bp_pops", 64'(pop_idx - pb), 64'(10));

    // Reset mid-frame with five words buffered, then a fresh K=4 frame.
    AXIS_TREADY = 1'b0;
    for (int i = 0; i < 5; i++) push_word(52'(200 + i), 3'd4);
    in_valid = 1'b0;
    check("pre_rst_count", 64'(dut.count), 64'(5));
    do_reset();
    AXIS_TREADY = 1'b1;
    check("post_rst_tvalid", 64'(AXIS_TVALID), 64'(0));
    lq0 = last_q.size(); pb = pop_idx;
    for (int i = 0; i < 30; i++) push_word(52'(300 + i), 3'd4);
    drain(100);
    check("rst_frame_pops", 64'(pop_idx - pb), 64'(30));
    if (last_q.size() > lq0) check("rst_frame_last", 64'(last_q[lq0] - pb), 64'(29));
    check("rst_frame_last_cnt", 64'(last_q.size() - lq0), 64'(1));

    // K changed from 4 to 2 at push 5 is ignored for the rest of the frame.
    lq0 = last_q.size(); pb = pop_idx;
    for (int i = 0; i < 30; i++) push_word(52'(400 + i), (i < 5) ? 3'd4 : 3'd2);
    drain(100);
    if (last_q.size() > lq0) check("kchg_last", 64'(last_q[lq0] - pb), 64'(29));
    check("kchg_last_cnt", 64'(last_q.size() - lq0), 64'(1));

    // Simultaneous push and pop at occupancy 3.
    AXIS_TREADY = 1'b0;
    for (int i = 0; i < 3; i++) push_word(52'(500 + i), 3'd4);
    AXIS_TREADY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_word(52'(503 + i), 3'd4);
      check("pp_count", 64'(dut.count), 64'(3));
    end
    drain(100);
    do_reset();

    // Random valid/ready over a K=2 frame then a K=3 frame.
    lq0 = last_q.size(); pb = pop_idx; fd0 = fd_count;
    rnd_mode = 1'b1;
    for (int i = 0; i < 98; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      push_word(52'h5_0000_0000_0000 + 52'($urandom), (i < 56) ? 3'd2 : 3'd3);
    end
    rnd_mode    = 1'b0;
    AXIS_TREADY = 1'b1;
    drain(200);
    check("rnd_pops", 64'(pop_idx - pb), 64'(98));
    check("rnd_last_cnt", 64'(last_q.size() - lq0), 64'(2));
    if (last_q.size() > lq0)     check("rnd_last0", 64'(last_q[lq0] - pb), 64'(55));
    if (last_q.size() > lq0 + 1) check("rnd_last1", 64'(last_q[lq0 + 1] - pb), 64'(97));
    check("rnd_frame_done", 64'(fd_count - fd0), 64'(2));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_stream_tx.md
OUTPUT_STREAM_TX -- requirements
Module: output_stream_tx

Interface
REQ-001 SHALL have parameter OUTW, default 52, output word width in bits.
REQ-002 SHALL have parameter R, default 9, X matrix rows.
REQ-003 SHALL have parameter C, default 8, X matrix columns.
REQ-004 SHALL have parameter MAXK, default 4, max kernel size.
REQ-005 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, >=2).
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-008 SHALL have port in_data  input  OUTW  convolution result from compute datapath.
REQ-009 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-010 SHALL have port in_ready  output  1  block can accept in_data this cycle.
REQ-011 SHALL have port K  input  $clog2(MAXK+1)  kernel size of current frame.
REQ-012 SHALL have port AXIS_TDATA  output  OUTW  stream data to consumer.
REQ-013 SHALL have port AXIS_TVALID  output  1  AXIS_TDATA/AXIS_TLAST valid.
REQ-014 SHALL have port AXIS_TREADY  input  1  consumer accepts word.
REQ-015 SHALL have port AXIS_TLAST  output  1  marks final word of a frame.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse, last word of frame transferred.

Function
REQ-017 SHALL define push = in_valid && in_ready, pop = AXIS_TVALID && AXIS_TREADY.
REQ-018 SHALL store {last_flag, in_data} per push in a DEPTH-entry circular FIFO with rd_ptr, wr_ptr, count (0..DEPTH).
REQ-019 SHALL drive in_ready = (count < DEPTH); no push accepted when full, even if a pop occurs the same cycle.
REQ-020 SHALL drive AXIS_TVALID = (count > 0), AXIS_TDATA/AXIS_TLAST from FIFO head entry; AXIS_TDATA content don't-care when AXIS_TVALID=0.
REQ-021 SHALL, once AXIS_TVALID=1, hold AXIS_TVALID, AXIS_TDATA, AXIS_TLAST stable until pop.
REQ-022 SHALL have latency 1: word pushed at edge n into empty FIFO appears with AXIS_TVALID=1 after edge n; no combinational in_data->AXIS_TDATA path.
REQ-023 SHALL update count: push only +1, pop only -1, push and pop together unchanged; pointers wrap modulo DEPTH.
REQ-024 SHALL keep push counter push_cnt (width $clog2(R*C)), +1 per push, wrapping to 0 after the frame's final push.
REQ-025 SHALL latch K into K_lat on the push where push_cnt==0; effective kernel Ke = K on that push, K_lat otherwise (K changes mid-frame ignored).
REQ-026 SHALL compute N = (R-Ke+1)*(C-Ke+1) unsigned, and set last_flag = (push_cnt == N-1); N=1 means every push is last.
REQ-027 SHALL assert frame_done for exactly the cycle after a pop with AXIS_TLAST=1 (registered).
REQ-028 SHALL handle back-to-back frames without idle cycles; frame boundaries determined solely by push_cnt.
REQ-029 SHALL treat K outside 1..min(R,C,MAXK) as unsupported; no behaviour guaranteed.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear rd_ptr, wr_ptr, count, push_cnt, K_lat, frame_done; outputs AXIS_TVALID=0, AXIS_TLAST=0, frame_done=0, in_ready=0.
REQ-031 SHALL, with reset=1 and count=0, present in_ready=1 from the first cycle after release.
REQ-032 SHALL on reset mid-frame discard buffered words; AXIS_TVALID falls immediately (asynchronously), next push starts a new frame (push_cnt=0).
REQ-033 SHALL leave FIFO storage array unreset; contents don't-care after reset.

Verification
REQ-034 SHALL test R=9,C=8,K=4, in_data=0..29, AXIS_TREADY=1 -> 30 words out in order, AXIS_TLAST only on word 29, frame_done one pulse.
REQ-035 SHALL test AXIS_TREADY=0 with 10 pushes (DEPTH=8) -> in_ready=0 after 8, count=8; TREADY=1 -> words 0..7 then 8,9 in order, no loss/duplication.
REQ-036 SHALL test random in_valid and AXIS_TREADY, two frames K=2 (56 words) then K=3 (42 words) -> TLAST on words 55 and 97 overall, data matches reference queue, TDATA stable while stalled.
REQ-037 SHALL test K changed from 4 to 2 at push 5 of a K=4 frame -> TLAST still on push 29 of that frame.
REQ-038 SHALL test reset=0 asserted mid-frame with 5 words buffered -> AXIS_TVALID=0 before next edge; after release, new K=4 frame gives TLAST on its 30th word.
REQ-039 SHALL test simultaneous push and pop at count=3 for 20 cycles -> count stays 3, output order preserved.
